// File: rtl/fmcw_defines.sv
`default_nettype none
// ============================================================================
// Module      : fmcw_defines (package)
// Description : Shared constants, FT2232H byte tags and packetizer state encoding.
// Revision    : 1.0
// ============================================================================
package fmcw_defines;

    localparam logic [7:0] FT_HDR = 8'h80;
    localparam logic [1:0] TAG_HI = 2'b00;
    localparam logic [1:0] TAG_LO = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } ft_state_t;

    function automatic logic [7:0] ft_hi_byte(input logic [11:0] sample);
        return {TAG_HI, sample[11:6]};
    endfunction

    function automatic logic [7:0] ft_lo_byte(input logic [11:0] sample);
        return {TAG_LO, sample[5:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered pointers; head and next-head
//               entries are visible combinationally.
// Revision    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [WIDTH-1:0]           next_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW-1:0]    w_rd_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_rd_next = r_rd_ptr[AW-1:0] + {{(AW-1){1'b0}}, 1'b1};
    assign count     = r_wr_ptr - r_rd_ptr;
    assign full      = (count == DEPTH[AW:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign rd_data   = r_mem[r_rd_ptr[AW-1:0]];
    assign next_data = r_mem[w_rd_next];

endmodule
`default_nettype wire

// File: rtl/ft_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : ft_packetizer
// Description : Buffers ADC samples and serialises them as header/high/low bytes
//               onto the FT2232H synchronous FIFO write interface.
// Revision    : 1.0
// ============================================================================
module ft_packetizer
    import fmcw_defines::*;
#(
    parameter int IW    = 12,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] data_i,
    input  logic          valid_i,
    input  logic          frame_start_i,
    input  logic          ft_txe_n,
    output logic [7:0]    ft_data_o,
    output logic          ft_wr_n,
    output logic          overflow_o
);

    localparam int AW = $clog2(DEPTH);

    ft_state_t       r_state;
    ft_state_t       w_next_state;
    logic            r_overflow;
    logic [IW:0]     w_head;
    logic [IW:0]     w_next_head;
    logic [AW:0]     w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_xfer;
    logic            w_pop;
    logic            w_push;
    logic            w_more;
    logic            w_next_fs;

    assign w_xfer = (r_state != ST_IDLE) && !ft_txe_n;
    assign w_pop  = (r_state == ST_LO) && w_xfer;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push = valid_i && !rst && (!w_full || w_pop);

    sync_fifo #(
        .WIDTH (IW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (w_push),
        .wr_data   ({frame_start_i, data_i}),
        .rd_en     (w_pop),
        .rd_data   (w_head),
        .next_data (w_next_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Successor of the popped head: the stored entry behind it, or the sample
    // being written right now when the popped entry was the only one.
    assign w_more    = (w_count > {{AW{1'b0}}, 1'b1}) || w_push;
    assign w_next_fs = (w_count > {{AW{1'b0}}, 1'b1}) ? w_next_head[IW] : frame_start_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (valid_i && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ft_data_o    = 8'h00;
        ft_wr_n      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_next_state = w_head[IW] ? ST_HDR : ST_HI;
            end
            ST_HDR: begin
                ft_wr_n   = 1'b0;
                ft_data_o = FT_HDR;
                if (w_xfer) w_next_state = ST_HI;
            end
            ST_HI: begin
                ft_wr_n   = 1'b0;
                ft_data_o = ft_hi_byte(w_head[IW-1:0]);
                if (w_xfer) w_next_state = ST_LO;
            end
            ST_LO: begin
                ft_wr_n   = 1'b0;
                ft_data_o = ft_lo_byte(w_head[IW-1:0]);
                if (w_xfer) begin
                    if (!w_more)        w_next_state = ST_IDLE;
                    else if (w_next_fs) w_next_state = ST_HDR;
                    else                w_next_state = ST_HI;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ft_packetizer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ft_packetizer
// Description : Scoreboard bench: expected FT byte stream queued at stimulus,
//               popped and compared by an independent byte monitor.
// Revision    : 1.0
// ============================================================================
module tb_ft_packetizer;

    localparam int IW    = 12;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          frame_start_i = 1'b0;
    logic          ft_txe_n = 1'b0;
    logic [7:0]    ft_data_o;
    logic          ft_wr_n;
    logic          overflow_o;

    int            checks = 0;
    int            failures = 0;
    logic [7:0]    exp_q[$];

    ft_packetizer #(.IW(IW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .frame_start_i (frame_start_i),
        .ft_txe_n      (ft_txe_n),
        .ft_data_o     (ft_data_o),
        .ft_wr_n       (ft_wr_n),
        .overflow_o    (overflow_o)
    );

    always #12.5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference encoding of one sample into its byte sequence.
    task automatic model_push(input int d, input bit fs);
        if (fs) exp_q.push_back(8'h80);
        exp_q.push_back(8'((d / 64) % 64));
        exp_q.push_back(8'(64 + (d % 64)));
    endtask

    // A byte leaves on the next rising edge when write is asserted and TX has room.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ft_wr_n === 1'b0 && ft_txe_n === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none", ft_data_o);
                end else begin
                    check("byte", {24'd0, ft_data_o}, {24'd0, exp_q.pop_front()});
                end
            end else if (!rst && ft_wr_n === 1'b1 && ft_data_o !== 8'h00) begin
                check("idle_data", {24'd0, ft_data_o}, 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input bit fs, input bit accepted);
        data_i        = IW'(d);
        frame_start_i = fs;
        valid_i       = 1'b1;
        if (accepted) model_push(d, fs);
        cyc();
        valid_i       = 1'b0;
        frame_start_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || ft_wr_n !== 1'b1) && n < 3000) begin
            cyc();
            n++;
        end
        check(name, {31'd0, n < 3000}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] held;
        do_reset();
        check("reset_wr_n", {31'd0, ft_wr_n}, 32'd1);
        check("reset_data", {24'd0, ft_data_o}, 32'd0);
        check("reset_ovf", {31'd0, overflow_o}, 32'd0);

        // Single sample latency: valid in cycle 0, first byte in cycle 2.
        send(12'hABC, 1'b0, 1'b1);
        check("lat_cycle1_wr_n", {31'd0, ft_wr_n}, 32'd1);
        cyc();
        check("lat_cycle2_wr_n", {31'd0, ft_wr_n}, 32'd0);
        check("lat_cycle2_data", {24'd0, ft_data_o}, 32'h2A);
        drain("drain_single");

        // Header sample followed by plain sample, back to back with no gaps.
        send(12'h123, 1'b1, 1'b1);
        send(12'h456, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("nogap_wr_n", {31'd0, ft_wr_n}, 32'd0);
            cyc();
        end
        check("after_pair_wr_n", {31'd0, ft_wr_n}, 32'd1);
        drain("drain_pair");

        // TXE stall while presenting the high byte.
        send(12'h5A7, 1'b0, 1'b1);
        cyc();
        ft_txe_n = 1'b1;
        held = ft_data_o;
        check("stall_enter_data", {24'd0, held}, 32'h16);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_hold_data", {24'd0, ft_data_o}, {24'd0, held});
            check("stall_hold_wr_n", {31'd0, ft_wr_n}, 32'd0);
        end
        ft_txe_n = 1'b0;
        drain("drain_stall");

        // Overflow: TX blocked, DEPTH+3 samples, only the first DEPTH survive.
        ft_txe_n = 1'b1;
        for (int k = 0; k < DEPTH + 3; k++) begin
            send(int'($urandom_range(0, 4095)), k[0], k < DEPTH);
            check("ovf_flag", {31'd0, overflow_o}, {31'd0, k >= DEPTH});
        end
        for (int i = 0; i < 4; i++) cyc();
        ft_txe_n = 1'b0;
        drain("drain_ovf");
        check("ovf_sticky", {31'd0, overflow_o}, 32'd1);
        do_reset();
        check("ovf_cleared", {31'd0, overflow_o}, 32'd0);

        // Reset while the low byte is being presented abandons the sample.
        send(12'h9C3, 1'b0, 1'b1);
        cyc();
        cyc();
        check("pre_rst_lo_data", {24'd0, ft_data_o}, 32'h43);
        check("pre_rst_pending", exp_q.size(), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        check("midrst_wr_n", {31'd0, ft_wr_n}, 32'd1);
        check("midrst_data", {24'd0, ft_data_o}, 32'd0);
        check("midrst_ovf", {31'd0, overflow_o}, 32'd0);
        for (int i = 0; i < 3; i++) cyc();
        check("midrst_quiet", {31'd0, ft_wr_n}, 32'd1);
        send(12'h3E1, 1'b1, 1'b1);
        drain("drain_after_rst");

        // Full-rate random stream: one sample every third cycle.
        for (int i = 0; i < 200; i++) begin
            send(int'($urandom_range(0, 4095)), (i % 50) == 0, 1'b1);
            cyc();
            cyc();
        end
        drain("drain_stream");
        check("stream_ovf", {31'd0, overflow_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
